// File: rtl/scram_ctrl_pkt_gen_pkg.sv
// Shared constants, state encoding and word-building helper for the scrambler
// control packet generator.
package scram_ctrl_pkt_gen_pkg;

    localparam int PKT_WORDS = 6;
    localparam int PID_W     = 13;
    localparam int CW_W      = 64;

    localparam int W_ADDR = 0;
    localparam int W_PID  = 1;
    localparam int W_CW0  = 2;
    localparam int W_CW1  = 3;
    localparam int W_CW2  = 4;
    localparam int W_CW3  = 5;

    localparam int W1_EN_BIT     = 15;
    localparam int W1_PARITY_BIT = 14;
    localparam int W1_PID_MSB    = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } pkt_state_e;

    function automatic logic [15:0] build_w1(input logic en, input logic parity,
                                             input logic [PID_W-1:0] pid);
        logic [15:0] w;
        w = '0;
        w[W1_EN_BIT]       = en;
        w[W1_PARITY_BIT]   = parity;
        w[W1_PID_MSB:0]    = pid;
        return w;
    endfunction

endpackage

// File: rtl/scram_ctrl_pkt_gen_if.sv
// Host request handshake plus outgoing control-packet stream.
interface scram_ctrl_pkt_gen_if
    import scram_ctrl_pkt_gen_pkg::*;
#(
    parameter int PIDRAM_DEPTH_BIT = 6
);
    logic                        cfg_req;
    logic                        cfg_rdy;
    logic [PIDRAM_DEPTH_BIT-1:0] cfg_index;
    logic [PID_W-1:0]            cfg_pid;
    logic                        cfg_en;
    logic                        cfg_parity;
    logic [CW_W-1:0]             cfg_cw;
    logic [15:0]                 sc_ctrl_pkt_d;
    logic                        sc_ctrl_pkt_dval;
    logic                        sc_ctrl_pkt_eof;

    modport master (
        output cfg_req, cfg_index, cfg_pid, cfg_en, cfg_parity, cfg_cw,
        input  cfg_rdy, sc_ctrl_pkt_d, sc_ctrl_pkt_dval, sc_ctrl_pkt_eof
    );

    modport slave (
        input  cfg_req, cfg_index, cfg_pid, cfg_en, cfg_parity, cfg_cw,
        output cfg_rdy, sc_ctrl_pkt_d, sc_ctrl_pkt_dval, sc_ctrl_pkt_eof
    );
endinterface

// File: rtl/scram_req_fifo.sv
// First-word-fall-through request FIFO; read data is valid whenever empty is low.
module scram_req_fifo #(
    parameter int WIDTH     = 85,
    parameter int DEPTH_BIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_BIT:0]   CNT_ONE = 1;
    localparam logic [DEPTH_BIT:0]   CNT_MAX = DEPTH;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_BIT-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BIT:0]   cnt_q;
    logic                 do_wr, do_rd;

    assign full    = (cnt_q == CNT_MAX);
    assign empty   = (cnt_q == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/scram_ctrl_pkt_gen.sv
// Queues scrambler configuration requests and serialises each as a 6-word stream.
// state | meaning: IDLE pop next entry | SEND one word per cycle | GAP inter-packet idle
module scram_ctrl_pkt_gen
    import scram_ctrl_pkt_gen_pkg::*;
#(
    parameter int FIFO_DEPTH_BIT   = 2,
    parameter int IFG_CYCLES       = 2,
    parameter int PIDRAM_DEPTH_BIT = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    scram_ctrl_pkt_gen_if.slave bus,
    input  logic                cfg_err_clr,
    output logic                busy,
    output logic                cfg_ovf,
    output logic [15:0]         pkt_cnt
);
    localparam int ENTRY_W = PIDRAM_DEPTH_BIT + 2 + PID_W + CW_W;
    localparam logic [3:0] GAP_LOAD = (IFG_CYCLES > 0) ? 4'(IFG_CYCLES - 1) : 4'd0;
    localparam logic [2:0] LAST_WORD = 3'(PKT_WORDS - 1);

    pkt_state_e           state_q, state_d;
    logic [2:0]           word_cnt_q, word_cnt_d;
    logic [3:0]           gap_cnt_q, gap_cnt_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;
    logic [15:0]          d_q, d_d;
    logic                 dval_q, dval_d;
    logic                 eof_q, eof_d;
    logic                 ovf_q, busy_q;
    logic [15:0]          pkt_cnt_q;

    logic                 fifo_full, fifo_empty, pop;
    logic [ENTRY_W-1:0]   fifo_rd_data;
    logic [15:0]          word_sel;

    logic [PIDRAM_DEPTH_BIT-1:0] ent_index;
    logic                        ent_en, ent_parity;
    logic [PID_W-1:0]            ent_pid;
    logic [CW_W-1:0]             ent_cw;

    scram_req_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH_BIT (FIFO_DEPTH_BIT)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.cfg_req),
        .wr_data ({bus.cfg_index, bus.cfg_en, bus.cfg_parity, bus.cfg_pid, bus.cfg_cw}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {ent_index, ent_en, ent_parity, ent_pid, ent_cw} = entry_q;

    always_comb begin
        word_sel = '0;
        case (int'(word_cnt_q))
            W_ADDR:  word_sel = 16'(ent_index);
            W_PID:   word_sel = build_w1(ent_en, ent_parity, ent_pid);
            W_CW0:   word_sel = ent_cw[63:48];
            W_CW1:   word_sel = ent_cw[47:32];
            W_CW2:   word_sel = ent_cw[31:16];
            W_CW3:   word_sel = ent_cw[15:0];
            default: word_sel = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        entry_d    = entry_q;
        pop        = 1'b0;
        d_d        = '0;
        dval_d     = 1'b0;
        eof_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    entry_d    = fifo_rd_data;
                    word_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                dval_d     = 1'b1;
                d_d        = word_sel;
                word_cnt_d = word_cnt_q + 3'd1;
                if (word_cnt_q == LAST_WORD) begin
                    eof_d = 1'b1;
                    if (IFG_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            entry_q    <= '0;
            d_q        <= '0;
            dval_q     <= 1'b0;
            eof_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            entry_q    <= entry_d;
            d_q        <= d_d;
            dval_q     <= dval_d;
            eof_q      <= eof_d;
            // A same-cycle overflow wins over the clear so no drop goes unreported.
            ovf_q      <= (bus.cfg_req & fifo_full) | (ovf_q & ~cfg_err_clr);
            busy_q     <= ~fifo_empty | (state_q != ST_IDLE);
            if (eof_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign bus.cfg_rdy          = ~fifo_full;
    assign bus.sc_ctrl_pkt_d    = d_q;
    assign bus.sc_ctrl_pkt_dval = dval_q;
    assign bus.sc_ctrl_pkt_eof  = eof_q;
    assign busy                 = busy_q;
    assign cfg_ovf              = ovf_q;
    assign pkt_cnt              = pkt_cnt_q;

endmodule

// File: tb/tb_scram_ctrl_pkt_gen.sv
// Scoreboard bench: three generators (IFG 2, 0, 3) share one request stream;
// each output stream is checked word-by-word against queued expected packets.
module tb_scram_ctrl_pkt_gen;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [5:0]  idx = '0;
    logic [12:0] pid = '0;
    logic        en = 1'b0;
    logic        par = 1'b0;
    logic [63:0] cw = '0;
    logic        err_clr = 1'b0;

    logic        rdy_w  [NI];
    logic [15:0] d_w    [NI];
    logic        dval_w [NI];
    logic        eof_w  [NI];
    logic        busy_w [NI];
    logic        ovf_w  [NI];
    logic [15:0] pc_w   [NI];

    logic [95:0] sb_q [NI][$];
    int          exp_pc [NI];
    int          words_seen [NI];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [95:0] mk_pkt(input logic [5:0] i, input logic [12:0] p,
                                           input logic e, input logic pa, input logic [63:0] c);
        return {10'd0, i, e, pa, 1'b0, p, c};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int IFG = (g == 0) ? 2 : (g == 1) ? 0 : 3;

        scram_ctrl_pkt_gen_if #(.PIDRAM_DEPTH_BIT(6)) bus ();

        assign bus.cfg_req    = req;
        assign bus.cfg_index  = idx;
        assign bus.cfg_pid    = pid;
        assign bus.cfg_en     = en;
        assign bus.cfg_parity = par;
        assign bus.cfg_cw     = cw;
        assign rdy_w[g]       = bus.cfg_rdy;
        assign d_w[g]         = bus.sc_ctrl_pkt_d;
        assign dval_w[g]      = bus.sc_ctrl_pkt_dval;
        assign eof_w[g]       = bus.sc_ctrl_pkt_eof;

        scram_ctrl_pkt_gen #(
            .FIFO_DEPTH_BIT   (2),
            .IFG_CYCLES       (IFG),
            .PIDRAM_DEPTH_BIT (6)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .bus         (bus.slave),
            .cfg_err_clr (err_clr),
            .busy        (busy_w[g]),
            .cfg_ovf     (ovf_w[g]),
            .pkt_cnt     (pc_w[g])
        );

        int          widx = 0;
        int          idle = 0;
        bit          b2b = 1'b0;
        logic [95:0] cur = '0;

        always @(negedge clk) begin
            if (!rst_n) begin
                widx = 0;
                idle = 0;
                b2b  = 1'b0;
            end else if (dval_w[g]) begin
                if (widx == 0) begin
                    if (b2b) chk($sformatf("gap_ifg%0d", IFG), 32'(idle), 32'(IFG + 1));
                    b2b = 1'b0;
                    if (sb_q[g].size() == 0) begin
                        chk($sformatf("unexpected_pkt_ifg%0d", IFG), 32'd1, 32'd0);
                        cur = '0;
                    end else begin
                        cur = sb_q[g].pop_front();
                    end
                end
                chk($sformatf("word%0d_ifg%0d", widx, IFG), 32'(d_w[g]), 32'(cur[95-16*widx -: 16]));
                chk($sformatf("eof%0d_ifg%0d", widx, IFG), 32'(eof_w[g]), 32'(widx == 5));
                words_seen[g]++;
                if (widx == 5) begin
                    widx = 0;
                    idle = 0;
                    b2b  = (sb_q[g].size() > 0);
                end else begin
                    widx++;
                end
            end else begin
                if (widx != 0) begin
                    chk($sformatf("dval_hole_ifg%0d", IFG), 32'(widx), 32'd0);
                    widx = 0;
                end
                chk($sformatf("idle_out_ifg%0d", IFG), 32'({eof_w[g], d_w[g]}), 32'd0);
                idle++;
            end
        end
    end

    task automatic drive_req(input logic [5:0] i, input logic [12:0] p, input logic e,
                             input logic pa, input logic [63:0] c);
        idx = i; pid = p; en = e; par = pa; cw = c;
        req = 1'b1;
        for (int k = 0; k < NI; k++) begin
            if (rdy_w[k]) begin
                sb_q[k].push_back(mk_pkt(i, p, e, pa, c));
                exp_pc[k]++;
            end
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NI; k++)
            if (sb_q[k].size() != 0 || busy_w[k] || dval_w[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !all_idle()) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n < budget), 32'd1);
        for (int k = 0; k < NI; k++)
            chk($sformatf("%s_pkt_cnt%0d", tag, k), 32'(pc_w[k]), 32'(exp_pc[k] & 16'hFFFF));
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            exp_pc[k] = 0;
            words_seen[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_rdy%0d", k), 32'(rdy_w[k]), 32'd1);
            chk($sformatf("rst_outs%0d", k),
                32'({d_w[k], dval_w[k], eof_w[k], busy_w[k], ovf_w[k]}), 32'd0);
            chk($sformatf("rst_pc%0d", k), 32'(pc_w[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: latency and exact word values.
        drive_req(6'h05, 13'h1ABC, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
        for (int k = 0; k < NI; k++) chk($sformatf("lat_n0_%0d", k), 32'(dval_w[k]), 32'd0);
        @(negedge clk);
        for (int k = 0; k < NI; k++) chk($sformatf("lat_n1_%0d", k), 32'(dval_w[k]), 32'd0);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("lat_n2_%0d", k), 32'(dval_w[k]), 32'd1);
            chk($sformatf("busy_mid%0d", k), 32'(busy_w[k]), 32'd1);
        end
        wait_drain("single", 100);

        // Disabled odd-key entry with all-ones PID.
        drive_req(6'h3F, 13'h1FFF, 1'b0, 1'b0, 64'hFEDC_BA98_7654_3210);
        wait_drain("w1_ones", 100);

        // Fill the FIFO, overflow it, and exercise the sticky overflow flag.
        for (int r = 0; r < 4; r++)
            drive_req(6'(r + 1), 13'(16'h0100 + r), r[0], r[1], {4{16'(16'h1000 + r)}});
        for (int k = 0; k < NI; k++) chk($sformatf("rdy_before5_%0d", k), 32'(rdy_w[k]), 32'd1);
        drive_req(6'h15, 13'h0555, 1'b1, 1'b0, 64'h5555_6666_7777_8888);
        for (int k = 0; k < NI; k++) chk($sformatf("rdy_full%0d", k), 32'(rdy_w[k]), 32'd0);
        drive_req(6'h16, 13'h0666, 1'b1, 1'b1, 64'h6666_6666_6666_6666);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("ovf_set%0d", k), 32'(ovf_w[k]), 32'd1);
            chk($sformatf("rdy_still_full%0d", k), 32'(rdy_w[k]), 32'd0);
        end
        err_clr = 1'b1;
        drive_req(6'h17, 13'h0777, 1'b0, 1'b1, 64'h7777_7777_7777_7777);
        err_clr = 1'b0;
        for (int k = 0; k < NI; k++) chk($sformatf("ovf_set_beats_clr%0d", k), 32'(ovf_w[k]), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int k = 0; k < NI; k++) chk($sformatf("ovf_cleared%0d", k), 32'(ovf_w[k]), 32'd0);
        wait_drain("overflow", 300);

        // Three queued requests: back-to-back gap timing per IFG.
        for (int r = 0; r < 3; r++)
            drive_req(6'(8 + r), 13'(13'h0A00 + r), 1'b1, r[0], {16'hC0DE, 16'(r), 32'hDEAD_BEEF});
        wait_drain("gap3", 300);

        // Randomised fields and spacing.
        for (int r = 0; r < 6; r++) begin
            drive_req(6'($urandom), 13'($urandom), 1'($urandom), 1'($urandom),
                      {32'($urandom), 32'($urandom)});
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_drain("random", 400);

        // Reset during W3 with two entries still queued.
        drive_req(6'h21, 13'h0123, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
        drive_req(6'h22, 13'h0124, 1'b1, 1'b0, 64'h1111_2222_3333_4444);
        drive_req(6'h23, 13'h0125, 1'b0, 1'b1, 64'h5555_6666_7777_8888);
        repeat (3) @(negedge clk);
        chk("w3_before_rst", 32'({dval_w[0], d_w[0]}), 32'h1BBBB);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_mid_outs%0d", k),
                32'({d_w[k], dval_w[k], eof_w[k], busy_w[k], ovf_w[k]}), 32'd0);
            chk($sformatf("rst_mid_pc%0d", k), 32'(pc_w[k]), 32'd0);
            chk($sformatf("rst_mid_rdy%0d", k), 32'(rdy_w[k]), 32'd1);
            sb_q[k].delete();
            exp_pc[k] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int snap [NI];
            for (int k = 0; k < NI; k++) snap[k] = words_seen[k];
            repeat (20) @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("post_rst_words%0d", k), 32'(words_seen[k] - snap[k]), 32'd0);
                chk($sformatf("post_rst_busy%0d", k), 32'(busy_w[k]), 32'd0);
                chk($sformatf("post_rst_pc%0d", k), 32'(pc_w[k]), 32'd0);
            end
        end

        // The block still works after the mid-packet reset.
        drive_req(6'h2A, 13'h1555, 1'b1, 1'b0, 64'h0F0F_F0F0_3C3C_C3C3);
        wait_drain("after_rst", 100);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scram_ctrl_pkt_gen.md
# scram_ctrl_pkt_gen

Builds and serialises scrambler control packets for the scrambler configuration path. Host-side configuration requests carry a table index, scrambled PID, enable and key parity, and a 64-bit control word. The block queues them and emits each as a 6-word, 16-bit stream on `sc_ctrl_pkt_d`/`dval`/`eof`. It is the transmitting end of the control-packet interface feeding the scrambler PID/service-key tables, and sits between the host register bank and the scrambler.

## Interface
- `FIFO_DEPTH_BIT`, 2: request FIFO holds 2^N entries.
- `IFG_CYCLES`, 2: minimum idle cycles (dval low) between packets; legal range 0..15.
- `PIDRAM_DEPTH_BIT`, 6: width of the table index.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_req` in 1: request valid, one-cycle strobe per request.
- `cfg_rdy` out 1: FIFO not full; a request is accepted on an edge where `cfg_req & cfg_rdy`.
- `cfg_index` in PIDRAM_DEPTH_BIT: target table entry.
- `cfg_pid` in 13: PID to scramble.
- `cfg_en` in 1: entry enable.
- `cfg_parity` in 1: current key select, 1 = even, 0 = odd.
- `cfg_cw` in 64: control word.
- `cfg_err_clr` in 1: clears `cfg_ovf`.
- `sc_ctrl_pkt_d` out 16: packet word.
- `sc_ctrl_pkt_dval` out 1: word valid.
- `sc_ctrl_pkt_eof` out 1: last word, coincident with the 6th dval.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `cfg_ovf` out 1: sticky; a request arrived while `cfg_rdy` was low.
- `pkt_cnt` out 16: packets sent, wraps.

## Operation
- **Packet format** (word order):
  - W0 = {zero-extend to 16, cfg_index}.
  - W1 = {cfg_en, cfg_parity, 1'b0, cfg_pid[12:0]}.
  - W2 = cw[63:48], W3 = cw[47:32], W4 = cw[31:16], W5 = cw[15:0].
- **FIFO entry**: 85 bits, {index, en, parity, pid, cw}. A request arriving while full is dropped and sets `cfg_ovf`. `cfg_ovf` is cleared by `cfg_err_clr`; a set and a clear in the same cycle leave it set.
- **`cfg_rdy`**: equals !full. A same-cycle pop does not raise it.
- **FSM states**:
  - IDLE: if FIFO non-empty, pop the entry into the output shift register, word_cnt=0, go to SEND.
  - SEND: drive one word per cycle with dval=1. When word_cnt==5, assert eof, increment pkt_cnt, then go to GAP (IFG_CYCLES>0) or IDLE (IFG_CYCLES=0).
  - GAP: count IFG_CYCLES idle cycles, then go to IDLE.
- **Stream rules**:
  - dval is contiguous for exactly 6 cycles per packet.
  - No stall input; the downstream is always ready.
  - `sc_ctrl_pkt_d` = 0 whenever dval=0.
  - eof is never high without dval.
- **Reset values**: all outputs 0 except `cfg_rdy`, which is 1 after reset.
- **Reset mid-packet**: outputs drop to 0 asynchronously, FIFO is flushed, and the partial packet is abandoned. The downstream receiver shares the reset domain.

## Timing
- Request accepted at edge N into an empty FIFO with the FSM in IDLE: FIFO write at edge N, pop at edge N+1, W0 dval high after edge N+2.
- Packet occupies 6 cycles; W5 is coincident with eof.
- Back-to-back spacing: W0 of the next packet appears IFG_CYCLES+1 cycles after the eof cycle (the IDLE pop cycle is included). With IFG_CYCLES=0 this is exactly 1 cycle.
- `pkt_cnt` updates on the edge ending the eof cycle; 0xFFFF wraps to 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package:
  - Packet length constant (6).
  - Word-index constants W_ADDR=0, W_PID=1, W_CW0..W_CW3=2..5.
  - W1 bit positions: EN=15, PARITY=14, PID=[12:0].
  - FSM state encoding IDLE/SEND/GAP.
- One sub-module, `scram_req_fifo`: parameterised synchronous FIFO with first-word-fall-through, full/empty flags, and width parameter 85.

## Test plan
- Single request, index=0x05, pid=0x1ABC, en=1, parity=1, cw=0x0123_4567_89AB_CDEF:
  - Words 0x0005, 0xDABC, 0x0123, 0x4567, 0x89AB, 0xCDEF with eof on the 6th.
  - First dval 2 cycles after acceptance.
  - pkt_cnt=1.
- Five requests on consecutive cycles (depth 4, idle FSM):
  - The 5th is accepted because the first has already popped.
  - A 6th on the next cycle is dropped; `cfg_ovf`=1, `cfg_rdy`=0 while full.
- IFG_CYCLES=0 and IFG_CYCLES=3 with 3 queued requests:
  - Gaps between eof and the next W0 are exactly 1 and 4 cycles.
  - dval is 0 and d=0 during gaps.
- en=0, parity=0, pid=0x1FFF: W1=0x1FFF.
- `rst_n` asserted during W3 of a packet with 2 entries queued:
  - Outputs are 0 immediately.
  - After release: busy=0, pkt_cnt=0, no words emitted.
- `cfg_err_clr` with a same-cycle overflow leaves `cfg_ovf`=1; `cfg_err_clr` alone clears it.
